// File: rtl/pci_target_decode.sv
// PCI target front end: address-phase detection, single-window decode and the
// DEVSEL#/TRDY#/STOP# handshake, with per-phase dword address and byte enables.
module pci_target_decode #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          WIN_BITS     = 8,
  parameter int          DEVSEL_SPEED = 0,
  parameter int          MAX_BURST    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Frame,
  input  logic        Iready,
  input  logic [31:0] AD,
  input  logic [3:0]  CBE,
  output logic        Devsel,
  output logic        Trdy,
  output logic        Stop,
  output logic [1:0]  RW,
  output logic [31:0] addr,
  output logic [3:0]  be,
  output logic        data_valid
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int LOW_W = WIN_BITS - 2;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_READ  = 2'd1;
  localparam logic [1:0] RW_WRITE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_TURN     = 3'd2,
    S_DATA     = 3'd3,
    S_STOPPING = 3'd4,
    S_BACKOFF  = 3'd5,
    S_MISS     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic               frame_prev_q, frame_prev_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         wait_q, wait_d;
  logic [1:0]         cmd_q, cmd_d;
  logic               devsel_q, devsel_d;
  logic               trdy_q, trdy_d;
  logic               stop_q, stop_d;
  logic [1:0]         rw_q, rw_d;

  logic               addr_phase;
  logic               addr_hit;
  logic [31:0]        addr_inc;
  logic [CNT_W-1:0]   count_inc;
  logic               unused_ad_bits;

  function automatic logic [1:0] cmd_kind(input logic [3:0] cmd);
    case (cmd)
      4'b0110, 4'b1100, 4'b1110: cmd_kind = RW_READ;
      4'b0111, 4'b1111:          cmd_kind = RW_WRITE;
      default:                   cmd_kind = RW_NONE;
    endcase
  endfunction

  // Increment stays inside the window: only the offset bits advance.
  function automatic logic [31:0] addr_next(input logic [31:0] a);
    logic [31:0] r;
    r = a;
    r[WIN_BITS-1:2] = a[WIN_BITS-1:2] + LOW_W'(1);
    return r;
  endfunction

  function automatic logic disconnect(input logic [31:0] a, input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(MAX_BURST - 1)) || (&a[WIN_BITS-1:2]);
  endfunction

  assign addr_phase     = (state_q == S_IDLE) && !Frame && frame_prev_q;
  assign addr_hit       = (AD[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]) && (cmd_kind(CBE) != RW_NONE);
  assign addr_inc       = addr_next(addr_q);
  assign count_inc      = count_q + CNT_W'(1);
  assign unused_ad_bits = ^AD[1:0];

  assign Devsel     = devsel_q;
  assign Trdy       = trdy_q;
  assign Stop       = stop_q;
  assign RW         = rw_q;
  assign addr       = addr_q;
  assign be         = be_q;
  assign data_valid = (state_q == S_DATA) && !Iready && !trdy_q;

  // Next-state and next-output computation for the target handshake.
  always_comb begin
    state_d      = state_q;
    frame_prev_d = Frame;
    addr_d       = addr_q;
    be_d         = be_q;
    count_d      = count_q;
    wait_d       = wait_q;
    cmd_d        = cmd_q;
    devsel_d     = devsel_q;
    trdy_d       = trdy_q;
    stop_d       = stop_q;
    rw_d         = rw_q;
    case (state_q)
      S_IDLE: begin
        if (addr_phase) begin
          addr_d  = {AD[31:2], 2'b00};
          cmd_d   = cmd_kind(CBE);
          count_d = {CNT_W{1'b0}};
          wait_d  = 2'd0;
          if (addr_hit) begin
            state_d = S_DECODE;
          end else begin
            state_d = S_MISS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (wait_q == 2'(DEVSEL_SPEED)) begin
          devsel_d = 1'b0;
          rw_d     = cmd_q;
          if (cmd_q == RW_WRITE) begin
            trdy_d  = 1'b0;
            stop_d  = ~disconnect(addr_q, count_q);
            state_d = S_DATA;
          end else begin
            state_d = S_TURN;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_TURN: begin
        trdy_d  = 1'b0;
        stop_d  = ~disconnect(addr_q, count_q);
        state_d = S_DATA;
      end
      S_DATA: begin
        be_d = CBE;
        if (!Iready) begin
          addr_d  = addr_inc;
          count_d = count_inc;
          if (Frame) begin
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
            stop_d   = 1'b1;
            rw_d     = RW_NONE;
            state_d  = S_BACKOFF;
          end else if (!stop_q) begin
            // Disconnect-with-data just completed; keep DEVSEL#/STOP# until FRAME# drops.
            trdy_d  = 1'b1;
            state_d = S_STOPPING;
          end else begin
            stop_d = ~disconnect(addr_inc, count_inc);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOPPING: begin
        if (Frame) begin
          devsel_d = 1'b1;
          trdy_d   = 1'b1;
          stop_d   = 1'b1;
          rw_d     = RW_NONE;
          state_d  = S_BACKOFF;
        end else begin
          state_d = S_STOPPING;
        end
      end
      S_BACKOFF: begin
        state_d = S_IDLE;
      end
      S_MISS: begin
        if (Frame && Iready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MISS;
        end
      end
      default: begin
        devsel_d = 1'b1;
        trdy_d   = 1'b1;
        stop_d   = 1'b1;
        rw_d     = RW_NONE;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns the target to an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_prev_q <= 1'b0;
      addr_q       <= 32'h0000_0000;
      be_q         <= 4'hF;
      count_q      <= {CNT_W{1'b0}};
      wait_q       <= 2'd0;
      cmd_q        <= RW_NONE;
      devsel_q     <= 1'b1;
      trdy_q       <= 1'b1;
      stop_q       <= 1'b1;
      rw_q         <= RW_NONE;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_prev_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      cmd_q        <= cmd_d;
      devsel_q     <= devsel_d;
      trdy_q       <= trdy_d;
      stop_q       <= stop_d;
      rw_q         <= rw_d;
    end
  end

endmodule
